// File: rtl/store_buffer.sv
// Post-commit store buffer: holds executed stores in program order, lets the
// commit stage mark them committed, drains committed stores one at a time to
// the data-cache port, and flags loads that hit a pending store word.
module store_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_wstrb,
    input  logic [31:0] st_data,
    input  logic        commit_store1_valid,
    input  logic        commit_store2_valid,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        sb_empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Access size implied by a legal strobe pattern.
    function automatic logic [1:0] size_of(input logic [3:0] strb);
        logic [1:0] size;
        case (strb)
            4'b1111:          size = 2'd2;
            4'b0011, 4'b1100: size = 2'd1;
            default:          size = 2'd0;
        endcase
        return size;
    endfunction

    logic [31:0]   ent_addr_r [DEPTH];
    logic [31:0]   ent_data_r [DEPTH];
    logic [3:0]    ent_strb_r [DEPTH];

    logic [PW-1:0] head_r, cmt_r, tail_r;
    logic [PW-1:0] head_s, cmt_s, tail_s;
    logic [PW-1:0] count_s, avail_s, ncmt_s;
    logic          enq_s, pop_s;
    state_t        state_r, state_s;

    logic          req_s;
    logic [1:0]    size_s;
    logic [31:0]   addr_s, wdata_s;
    logic [3:0]    wstrb_s;

    logic [IW-1:0] off_s [DEPTH];
    logic [DEPTH-1:0] hit_s;

    // Pointer arithmetic: enqueue, saturating commit, flush rollback, pop.
    always_comb begin
        count_s  = tail_r - head_r;
        st_ready = (count_s < DEPTH_P);
        enq_s    = st_valid && st_ready && !flush;
        pop_s    = (state_r == ST_WAIT) && data_data_ok;
        avail_s  = tail_r - cmt_r;
        ncmt_s   = {{(PW-1){1'b0}}, commit_store1_valid}
                 + {{(PW-1){1'b0}}, commit_store2_valid};
        if (ncmt_s > avail_s) begin
            cmt_s = tail_r;
        end else begin
            cmt_s = cmt_r + ncmt_s;
        end
        if (flush) begin
            tail_s = cmt_s;
        end else if (enq_s) begin
            tail_s = tail_r + ONE_P;
        end else begin
            tail_s = tail_r;
        end
        if (pop_s) begin
            head_s = head_r + ONE_P;
        end else begin
            head_s = head_r;
        end
    end

    // Pointer and drain-state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r  <= {PW{1'b0}};
            cmt_r   <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            state_r <= ST_IDLE;
        end else begin
            head_r  <= head_s;
            cmt_r   <= cmt_s;
            tail_r  <= tail_s;
            state_r <= state_s;
        end
    end

    // Entry storage; only slots in [head, tail) are ever read as valid.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            ent_addr_r[tail_r[IW-1:0]] <= st_addr;
            ent_data_r[tail_r[IW-1:0]] <= st_data;
            ent_strb_r[tail_r[IW-1:0]] <= st_wstrb;
        end
    end

    // Drain FSM next state; the post-pop check looks for more committed work.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmt_r != head_r) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    if (cmt_r != head_s) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request fields for next cycle, taken from the entry that will be oldest.
    always_comb begin
        req_s = (state_s == ST_REQ);
        if (req_s) begin
            addr_s  = ent_addr_r[head_s[IW-1:0]];
            wdata_s = ent_data_r[head_s[IW-1:0]];
            wstrb_s = ent_strb_r[head_s[IW-1:0]];
            size_s  = size_of(ent_strb_r[head_s[IW-1:0]]);
        end else begin
            addr_s  = 32'h0000_0000;
            wdata_s = 32'h0000_0000;
            wstrb_s = 4'b0000;
            size_s  = 2'd0;
        end
    end

    // Memory request outputs, registered so they hold steady while in REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'h0000_0000;
            data_wdata <= 32'h0000_0000;
            data_wstrb <= 4'b0000;
        end else begin
            data_req   <= req_s;
            data_wr    <= req_s;
            data_size  <= size_s;
            data_addr  <= addr_s;
            data_wdata <= wdata_s;
            data_wstrb <= wstrb_s;
        end
    end

    // Load conflict over every resident entry, committed or in flight.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off_s[i] = IW'(i) - head_r[IW-1:0];
            hit_s[i] = ({1'b0, off_s[i]} < count_s)
                    && ((ent_addr_r[i] & WORD_MASK) == (ld_addr & WORD_MASK));
        end
        ld_conflict = |hit_s;
        sb_empty    = (count_s == {PW{1'b0}}) && (state_r == ST_IDLE);
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes are queued as stores are
// driven and checked by a memory-port responder as the buffer issues them.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = 32'h0;
    logic [3:0]  st_wstrb = 4'h0;
    logic [31:0] st_data = 32'h0;
    logic        commit_store1_valid = 1'b0;
    logic        commit_store2_valid = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_conflict, sb_empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   writes = 0;
    bit   mem_stall = 1'b0;
    bit   hold_dok = 1'b0;
    bit   pending = 1'b0;

    store_buffer #(.DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wstrb(st_wstrb), .st_data(st_data),
        .commit_store1_valid(commit_store1_valid),
        .commit_store2_valid(commit_store2_valid),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    // Memory responder: accepts a request, answers data_ok one cycle later.
    always begin : responder
        exp_t e;
        @(posedge clk);
        #1;
        if (!resetn) begin
            pending = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
        end else if (pending) begin
            data_addr_ok = 1'b0;
            if (hold_dok) begin
                data_data_ok = 1'b0;
            end else begin
                data_data_ok = 1'b1;
                pending = 1'b0;
            end
        end else begin
            data_data_ok = 1'b0;
            if (data_req && !mem_stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got addr=%h data=%h strb=%b, expected no write",
                             data_addr, data_wdata, data_wstrb);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_wr, data_addr, data_wdata, data_wstrb, data_size} !==
                        {1'b1, e.addr, e.data, e.strb, e.size}) begin
                        miscompares++;
                        $display("FAIL write_fields: got wr=%b addr=%h data=%h strb=%b size=%0d, expected wr=1 addr=%h data=%h strb=%b size=%0d",
                                 data_wr, data_addr, data_wdata, data_wstrb, data_size,
                                 e.addr, e.data, e.strb, e.size);
                    end
                end
                writes++;
                data_addr_ok = 1'b1;
                pending = 1'b1;
            end else begin
                data_addr_ok = 1'b0;
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [1:0] z);
        exp_t e;
        e.addr = a; e.data = d; e.strb = s; e.size = z;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        st_valid = 1'b1; st_addr = a; st_wstrb = s; st_data = d;
        while (!st_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        st_valid = 1'b0;
    endtask

    task automatic commit(input bit two);
        commit_store1_valid = 1'b1;
        commit_store2_valid = two;
        tick();
        commit_store1_valid = 1'b0;
        commit_store2_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (!(exp_q.size() == 0 && sb_empty) && n < 400) begin
            tick();
            n++;
        end
        ok = (exp_q.size() == 0) && sb_empty;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        vectors++;
        if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b wr=%b size=%0d addr=%h wdata=%h strb=%b, expected all 0",
                     data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb);
        end
        vectors++;
        if ({st_ready, sb_empty, ld_conflict} !== 3'b110) begin
            miscompares++;
            $display("FAIL reset_status: got ready/empty/conflict=%b, expected 110",
                     {st_ready, sb_empty, ld_conflict});
        end
        tick(); tick();
        resetn = 1'b1;
        tick();
        vectors++;
        if ({st_ready, sb_empty, data_req} !== 3'b110) begin
            miscompares++;
            $display("FAIL post_reset: got ready/empty/req=%b, expected 110",
                     {st_ready, sb_empty, data_req});
        end
    endtask

    task automatic test_basic();
        bit ok;
        exp_q.push_back(mk(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 2'd2));
        enq(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
        commit_store1_valid = 1'b1;
        ld_addr = 32'h0000_1002;
        #1;
        vectors++;
        if (ld_conflict !== 1'b1 || sb_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_resident: got conflict=%b empty=%b, expected conflict=1 empty=0",
                     ld_conflict, sb_empty);
        end
        tick();
        commit_store1_valid = 1'b0;
        vectors++;
        if (data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_req_early: got data_req=%b, expected 0 one cycle after commit", data_req);
        end
        tick();
        vectors++;
        if ({data_req, data_addr, data_size, data_wdata} !== {1'b1, 32'h0000_1000, 2'd2, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL basic_req: got req=%b addr=%h size=%0d wdata=%h, expected 1 00001000 2 deadbeef",
                     data_req, data_addr, data_size, data_wdata);
        end
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_drain: got empty=%b pending_writes=%0d, expected empty=1 and 0 pending",
                     sb_empty, exp_q.size());
        end
    endtask

    task automatic test_flush_committed();
        bit ok;
        int w0 = writes;
        exp_q.push_back(mk(32'h0000_3000, 32'h1111_0000, 4'b1111, 2'd2));
        exp_q.push_back(mk(32'h0000_3004, 32'h2222_0000, 4'b1111, 2'd2));
        enq(32'h0000_3000, 4'b1111, 32'h1111_0000);
        enq(32'h0000_3004, 4'b1111, 32'h2222_0000);
        enq(32'h0000_3008, 4'b1111, 32'h3333_0000);
        commit(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ld_addr = 32'h0000_3008;
        #1;
        vectors++;
        if (ld_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_dropped_conflict: got %b, expected 0", ld_conflict);
        end
        wait_drain(ok);
        vectors++;
        if (!ok || (writes - w0) != 2) begin
            miscompares++;
            $display("FAIL flush_committed_drain: got empty=%b writes=%0d, expected empty=1 writes=2",
                     sb_empty, writes - w0);
        end
    endtask

    task automatic test_full_wrap();
        bit ok;
        int n = 0;
        int w0 = writes;
        mem_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(32'h0000_4000 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'b1111, 2'd2));
            enq(32'h0000_4000 + 32'(i * 4), 4'b1111, 32'hA500_0000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) commit(1'b1);
        vectors++;
        if (st_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got st_ready=%b, expected 0 with 8 entries", st_ready);
        end
        st_valid = 1'b1; st_addr = 32'h0000_0BAD; st_wstrb = 4'b1111; st_data = 32'h0BAD_0BAD;
        tick();
        st_valid = 1'b0;
        tick();
        vectors++;
        if (st_ready !== 1'b0 || data_req !== 1'b1) begin
            miscompares++;
            $display("FAIL full_stalled: got ready=%b req=%b, expected ready=0 req=1", st_ready, data_req);
        end
        mem_stall = 1'b0;
        @(negedge clk);
        while (!data_data_ok && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (data_data_ok !== 1'b1 || st_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_cycle: got data_ok=%b ready=%b, expected data_ok=1 ready=0",
                     data_data_ok, st_ready);
        end
        @(negedge clk);
        vectors++;
        if (st_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_freed: got st_ready=%b, expected 1 after pop", st_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 8; i < 20; i++) begin
            exp_q.push_back(mk(32'h0000_4000 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'b1111, 2'd2));
            enq(32'h0000_4000 + 32'(i * 4), 4'b1111, 32'hA500_0000 + 32'(i));
            commit(1'b0);
        end
        wait_drain(ok);
        vectors++;
        if (!ok || (writes - w0) != 20) begin
            miscompares++;
            $display("FAIL wrap_drain: got empty=%b writes=%0d, expected empty=1 writes=20",
                     sb_empty, writes - w0);
        end
    endtask

    task automatic test_strobes();
        bit ok;
        exp_q.push_back(mk(32'h0000_2001, 32'h0000_AB00, 4'b0010, 2'd0));
        exp_q.push_back(mk(32'h0000_2002, 32'h1234_0000, 4'b1100, 2'd1));
        enq(32'h0000_2001, 4'b0010, 32'h0000_AB00);
        enq(32'h0000_2002, 4'b1100, 32'h1234_0000);
        ld_addr = 32'h0000_2003;
        #1;
        vectors++;
        if (ld_conflict !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_same_word: got %b, expected 1", ld_conflict);
        end
        ld_addr = 32'h0000_2004;
        #1;
        vectors++;
        if (ld_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_next_word: got %b, expected 0", ld_conflict);
        end
        commit(1'b1);
        wait_drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL strobes_drain: got empty=%b pending_writes=%0d, expected 1 and 0",
                     sb_empty, exp_q.size());
        end
    endtask

    task automatic test_flush_commit();
        bit ok;
        int w0 = writes;
        exp_q.push_back(mk(32'h0000_5000, 32'h5555_AAAA, 4'b0011, 2'd1));
        enq(32'h0000_5000, 4'b0011, 32'h5555_AAAA);
        enq(32'h0000_5004, 4'b1111, 32'h6666_BBBB);
        commit_store1_valid = 1'b1;
        flush = 1'b1;
        tick();
        commit_store1_valid = 1'b0;
        flush = 1'b0;
        ld_addr = 32'h0000_5004;
        #1;
        vectors++;
        if (ld_conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_commit_dropped: got conflict=%b, expected 0", ld_conflict);
        end
        wait_drain(ok);
        vectors++;
        if (!ok || (writes - w0) != 1) begin
            miscompares++;
            $display("FAIL flush_commit_drain: got empty=%b writes=%0d, expected empty=1 writes=1",
                     sb_empty, writes - w0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        int w0;
        bit saw_req = 1'b0;
        hold_dok = 1'b1;
        exp_q.push_back(mk(32'h0000_6000, 32'h7777_7777, 4'b1111, 2'd2));
        enq(32'h0000_6000, 4'b1111, 32'h7777_7777);
        commit(1'b0);
        while (!pending && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors++;
        if (!pending || sb_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_reached: got accepted=%b empty=%b, expected accepted=1 empty=0",
                     pending, sb_empty);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({sb_empty, st_ready, data_req, data_addr} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got empty=%b ready=%b req=%b addr=%h, expected 1 1 0 0",
                     sb_empty, st_ready, data_req, data_addr);
        end
        hold_dok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        w0 = writes;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_req) saw_req = 1'b1;
        end
        vectors++;
        if (saw_req || sb_empty !== 1'b1 || writes != w0) begin
            miscompares++;
            $display("FAIL after_reset_idle: got req_seen=%b empty=%b writes=%0d, expected 0 1 0",
                     saw_req, sb_empty, writes - w0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_committed();
        test_full_wrap();
        test_strobes();
        test_flush_commit();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the execute load/store pipe and the data-cache SRAM-style port. Stores enter in program order when they execute and stay speculative until the commit stage marks them committed via `commit_store1_valid`/`commit_store2_valid`. Committed stores then drain to memory one at a time. A flush discards only uncommitted entries, and loads get a word-address conflict flag so they do not bypass pending stores.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥4
- `clk`  in  1  clock, all state on rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `flush`  in  1  pipeline flush; drop all uncommitted entries
- `st_valid`  in  1  store enqueue request from the load/store pipe (program order)
- `st_ready`  out  1  buffer can accept an enqueue this cycle
- `st_addr`  in  32  store byte address
- `st_wstrb`  in  4  byte strobes; legal values are 0001/0010/0100/1000/0011/1100/1111
- `st_data`  in  32  store data, byte-lane aligned
- `commit_store1_valid`  in  1  oldest uncommitted entry commits
- `commit_store2_valid`  in  1  second-oldest uncommitted entry commits; only asserted with store1
- `data_req`  out  1  memory request
- `data_wr`  out  1  constant 1 when `data_req` is high
- `data_size`  out  2  0 = byte, 1 = half, 2 = word
- `data_addr`  out  32  request address
- `data_wdata`  out  32  request data
- `data_wstrb`  out  4  request strobes
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  write done; arrives at least 1 cycle after `data_addr_ok`
- `ld_addr`  in  32  load address to check
- `ld_conflict`  out  1  some resident entry has `addr[31:2] == ld_addr[31:2]`
- `sb_empty`  out  1  no resident entries, and no transaction in flight

## Operation
- Circular array of `DEPTH` entries {addr, wstrb, data}.
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit: `head` (oldest, drain point), `cmt` (first uncommitted), `tail` (next free).
- Invariant: head ≤ cmt ≤ tail in modular order.
- Resident count is `tail-head`. Committed count is `cmt-head`.
- Enqueue fires when `st_valid && st_ready && !flush`. It writes the entry at `tail`, then `tail+1`.
- `st_ready = (tail-head) < DEPTH`. An enqueue attempt while full is ignored.
- Commit advances `cmt` by `commit_store1_valid + commit_store2_valid`.
  - Commit of a nonexistent entry (cmt==tail) is a protocol error.
  - In that case `cmt` saturates at `tail`.
- Flush sets `tail <= cmt_next`, where `cmt_next` is `cmt` after this cycle's commits.
  - Commits in the flush cycle are therefore kept.
  - An enqueue in the flush cycle is dropped.
  - Committed entries and any in-flight drain are unaffected.
- Drain FSM:
  - IDLE: if `cmt != head`, go to REQ.
  - REQ: drive `data_req=1` with the fields of entry `head`; hold them stable. On `data_addr_ok`, go to WAIT.
  - WAIT: `data_req=0`. On `data_data_ok`, set `head+1`. Then go to REQ if another committed entry exists (after this pop), else IDLE.
- `data_size` derives from `wstrb`:
  - 1111 → 2
  - 0011 / 1100 → 1
  - single bit → 0
- `data_addr` is `st_addr` unchanged.
- `ld_conflict` is combinational over all resident entries [head, tail), committed or not. It includes the entry in flight and excludes a same-cycle enqueue.
- Reset values:
  - all pointers 0, FSM IDLE
  - `data_req=0`, `data_wr=0`, `data_size=0`, `data_addr/wdata/wstrb=0`
  - `st_ready=1`, `ld_conflict=0`, `sb_empty=1`
- Reset mid-transaction abandons it. The memory side is reset by the same `resetn`.

## Timing
- Enqueue in cycle N: entry is resident from N+1 (`ld_conflict`, commit-eligible).
- Commit in cycle N: `cmt` updated at N+1. `data_req` rises at earliest N+2 (IDLE→REQ registered, REQ drives request).
- `data_req` stays high and fields stay constant from REQ entry until the `data_addr_ok` cycle inclusive.
- `data_data_ok` in cycle M: entry freed at M+1. `st_ready` reflects the freed slot at M+1. Back-to-back drain has `data_req` high again at M+1.
- Full and simultaneous pop: `st_ready` is based on registered count, so it stays 0 in cycle M.
- Wrap-around: pointer MSB distinguishes full (`tail-head == DEPTH`) from empty (`tail == head`).
- `data_data_ok` outside WAIT and `data_addr_ok` outside REQ are ignored.

## Test plan
- Reset, enqueue a store {0x1000, 1111, 0xDEADBEEF}, commit it one cycle later:
  - `data_req` high with addr 0x1000, size 2, wdata 0xDEADBEEF.
  - After `data_addr_ok`, then `data_data_ok`, `sb_empty=1`.
- Enqueue 3 stores, commit first 2 via store1+store2 in one cycle, assert `flush` the next cycle:
  - exactly 2 writes drained in order; 3rd never issued.
  - `ld_conflict` for the 3rd address is 0 after the flush.
- Fill 8 entries with memory stalled (no `addr_ok`):
  - `st_ready=0` and a 9th `st_valid` is ignored.
  - After one `data_data_ok`, `st_ready=1` the next cycle.
  - Drive 20 stores total to exercise pointer wrap; all data matches in order.
- Strobes 0010 at 0x2001 → size 0; 1100 at 0x2002 → size 1.
  - `ld_addr=0x2003` gives `ld_conflict=1`; `0x2004` gives 0.
- Flush and commit1 in the same cycle with 2 uncommitted entries: first is kept and drained, second dropped.
- Deassert `resetn` mid-WAIT: outputs go to reset values immediately. After release, `sb_empty=1` and no request is issued.
